cell_window_scheduler: RTL and testbench

- Sequences the 3x3 cell processor across one raster-order image frame.
- Accepts a frame instruction and a pixel stream, and keeps three line buffers of IMAGE_WIDTH pixels (cellBuf_t organisation).
- Forms one 3x3 cell per interior pixel and issues it with the frame opcode and user input to the cell processor over a valid/ready handshake.
- Sits between the image input buffer and the CellProcessingPkg datapath; reports frame completion.

---
 rtl/cell_window_scheduler.sv | 176 +++++++++++++++++
 tb/tb_cell_window_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_window_scheduler.sv
// Raster-order 3x3 window scheduler: line-buffers a pixel stream and issues one cell
// per interior pixel, tagged with the latched frame opcode and user input.
module cell_window_scheduler #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int PIXEL_DEPTH  = 24,
  parameter int CELL_N       = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [3:0]               instr_opcode,
  input  logic [23:0]              instr_user,
  output logic                     instr_error,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [PIXEL_DEPTH-1:0]   pix_data,
  output logic                     cell_valid,
  input  logic                     cell_ready,
  output logic [9*PIXEL_DEPTH-1:0] cell_data,
  output logic [3:0]               cell_opcode,
  output logic [23:0]              cell_user,
  output logic [9:0]               cell_x,
  output logic [8:0]               cell_y,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int X_W = $clog2(IMAGE_WIDTH);
  localparam int Y_W = $clog2(IMAGE_HEIGHT);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMAGE_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMAGE_HEIGHT - 1);
  localparam logic [3:0]     OP_AVG = 4'd11;

  generate
    if (CELL_N != 3) begin : g_cellNCheck
      $error("cell_window_scheduler: CELL_N must be 3");
    end
    if (IMAGE_WIDTH < 3 || IMAGE_HEIGHT < 3) begin : g_sizeCheck
      $error("cell_window_scheduler: image must be at least 3x3");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                   r_state;
  logic [X_W-1:0]           r_x;
  logic [Y_W-1:0]           r_y;
  logic [1:0]               r_rowSel;
  logic [3:0]               r_op;
  logic [23:0]              r_user;
  logic                     r_cellValid;
  logic [9*PIXEL_DEPTH-1:0] r_cellData;
  logic [9:0]               r_cellX;
  logic [8:0]               r_cellY;
  logic                     r_instrError;
  logic                     r_frameDone;
  logic [PIXEL_DEPTH-1:0]   r_lineBuf [3][IMAGE_WIDTH];
  logic [PIXEL_DEPTH-1:0]   r_win [3][3];

  logic                     w_pixAccept;
  logic [1:0]               w_oldSel;
  logic [1:0]               w_midSel;
  logic [PIXEL_DEPTH-1:0]   w_newCol [3];
  logic [9*PIXEL_DEPTH-1:0] w_cellNext;

  assign w_pixAccept = pix_valid && pix_ready;
  // Buffer (y-2)%3 == (y+1)%3 holds the oldest row, (y-1)%3 == (y+2)%3 the middle one.
  assign w_oldSel    = (r_rowSel == 2'd2) ? 2'd0 : r_rowSel + 2'd1;
  assign w_midSel    = (r_rowSel == 2'd0) ? 2'd2 : r_rowSel - 2'd1;
  assign w_newCol[0] = r_lineBuf[w_oldSel][r_x];
  assign w_newCol[1] = r_lineBuf[w_midSel][r_x];
  assign w_newCol[2] = pix_data;

  always_comb begin
    w_cellNext = '0;
    for (int r = 0; r < 3; r++) begin
      w_cellNext[PIXEL_DEPTH*(r*3+0) +: PIXEL_DEPTH] = r_win[r][1];
      w_cellNext[PIXEL_DEPTH*(r*3+1) +: PIXEL_DEPTH] = r_win[r][2];
      w_cellNext[PIXEL_DEPTH*(r*3+2) +: PIXEL_DEPTH] = w_newCol[r];
    end
  end

  always_ff @(posedge clk) begin
    if (w_pixAccept) r_lineBuf[r_rowSel][r_x] <= pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_rowSel     <= '0;
      r_op         <= '0;
      r_user       <= '0;
      r_cellValid  <= 1'b0;
      r_cellData   <= '0;
      r_cellX      <= '0;
      r_cellY      <= '0;
      r_instrError <= 1'b0;
      r_frameDone  <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
    end else begin
      r_instrError <= 1'b0;
      r_frameDone  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            if (instr_opcode <= OP_AVG) begin
              r_op     <= instr_opcode;
              r_user   <= instr_user;
              r_x      <= '0;
              r_y      <= '0;
              r_rowSel <= '0;
              for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
              r_state  <= S_RUN;
            end else begin
              r_instrError <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (r_cellValid && cell_ready) r_cellValid <= 1'b0;
          if (w_pixAccept) begin
            // Clearing the window at end of row keeps cells from spanning two rows.
            for (int r = 0; r < 3; r++) begin
              r_win[r][0] <= (r_x == X_LAST) ? '0 : r_win[r][1];
              r_win[r][1] <= (r_x == X_LAST) ? '0 : r_win[r][2];
              r_win[r][2] <= (r_x == X_LAST) ? '0 : w_newCol[r];
            end
            if (r_x >= X_W'(2) && r_y >= Y_W'(2)) begin
              r_cellValid <= 1'b1;
              r_cellData  <= w_cellNext;
              r_cellX     <= 10'(r_x - X_W'(1));
              r_cellY     <= 9'(r_y - Y_W'(1));
            end
            if (r_x == X_LAST) begin
              r_x      <= '0;
              r_y      <= r_y + Y_W'(1);
              r_rowSel <= (r_rowSel == 2'd2) ? 2'd0 : r_rowSel + 2'd1;
              if (r_y == Y_LAST) r_state <= S_DRAIN;
            end else begin
              r_x <= r_x + X_W'(1);
            end
          end
        end
        S_DRAIN: begin
          // Stay one extra cycle so busy drops only after the frame_done pulse.
          if (r_frameDone) begin
            r_state <= S_IDLE;
          end else if (r_cellValid && cell_ready) begin
            r_cellValid <= 1'b0;
            r_frameDone <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign pix_ready   = (r_state == S_RUN) && (!r_cellValid || cell_ready);
  assign busy        = (r_state != S_IDLE);
  assign instr_error = r_instrError;
  assign frame_done  = r_frameDone;
  assign cell_valid  = r_cellValid;
  assign cell_data   = r_cellData;
  assign cell_opcode = r_op;
  assign cell_user   = r_user;
  assign cell_x      = r_cellX;
  assign cell_y      = r_cellY;

endmodule

// File: tb/tb_cell_window_scheduler.sv
// Scoreboard bench for cell_window_scheduler on a small 5x4 frame: a frame-image model
// predicts every cell, and a negedge monitor checks cells, frame_done and idle timing.
module tb_cell_window_scheduler;

  localparam int W     = 5;
  localparam int H     = 4;
  localparam int PD    = 24;
  localparam int CELLS = (W - 2) * (H - 2);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;

  typedef struct packed {
    logic [9*PD-1:0] data;
    logic [9:0]      x;
    logic [8:0]      y;
    logic [3:0]      op;
    logic [23:0]     user;
    logic            last;
  } cell_t;

  logic            clk;
  logic            rst_n;
  logic            instr_valid;
  logic            instr_ready;
  logic [3:0]      instr_opcode;
  logic [23:0]     instr_user;
  logic            instr_error;
  logic            pix_valid;
  logic            pix_ready;
  logic [PD-1:0]   pix_data;
  logic            cell_valid;
  logic            cell_ready;
  logic [9*PD-1:0] cell_data;
  logic [3:0]      cell_opcode;
  logic [23:0]     cell_user;
  logic [9:0]      cell_x;
  logic [8:0]      cell_y;
  logic            busy;
  logic            frame_done;

  cell_t         expQ[$];
  logic [PD-1:0] img [H][W];
  int            vectors = 0;
  int            miscompares = 0;
  int            cellsSeen = 0;
  int            doneCount = 0;
  int            readyMode = 0;
  bit            stallDone = 0;
  bit            expDoneNext = 0;
  bit            prevDone = 0;

  cell_window_scheduler #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_DEPTH(PD), .CELL_N(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_user(instr_user), .instr_error(instr_error),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_data(cell_data),
    .cell_opcode(cell_opcode), .cell_user(cell_user),
    .cell_x(cell_x), .cell_y(cell_y), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented cell must match the head of the expected queue.
  initial begin : monitor
    cell_t e;
    bit    nextDone;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expDoneNext = 0;
        prevDone    = 0;
      end else begin
        checkOutput("frame_done", frame_done, expDoneNext);
        if (prevDone) begin
          checkOutput("busy_after_done", busy, 1'b0);
          checkOutput("instr_ready_after_done", instr_ready, 1'b1);
        end
        prevDone = expDoneNext;
        if (frame_done) doneCount++;
        nextDone = 0;
        if (cell_valid && !cell_ready) checkOutput("pix_ready_stall", pix_ready, 1'b0);
        if (cell_valid) begin
          if (expQ.size() == 0) begin
            checkOutput("cell_unexpected", cell_valid, 1'b0);
          end else begin
            e = expQ[0];
            checkOutput("cell_data", cell_data, e.data);
            checkOutput("cell_x", cell_x, e.x);
            checkOutput("cell_y", cell_y, e.y);
            checkOutput("cell_opcode", cell_opcode, e.op);
            checkOutput("cell_user", cell_user, e.user);
            if (cell_ready) begin
              void'(expQ.pop_front());
              cellsSeen++;
              nextDone = e.last;
            end
          end
        end
        expDoneNext = nextDone;
      end
    end
  end

  // Consumer: always ready, a single 4-cycle stall at the third cell, or random.
  initial begin : readyDriver
    cell_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1: begin
          if (cellsSeen == 2 && !stallDone) begin
            cell_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            cell_ready = 1'b1;
            stallDone  = 1;
          end else begin
            cell_ready = 1'b1;
          end
        end
        2:       cell_ready = 1'($urandom_range(0, 1));
        default: cell_ready = 1'b1;
      endcase
    end
  end

  task automatic sendInstr(input logic [3:0] op, input logic [23:0] user, output bit ok);
    @(posedge clk);
    #1;
    instr_valid  = 1'b1;
    instr_opcode = op;
    instr_user   = user;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (instr_ready) ok = 1;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    if (!ok) checkOutput("instr_timeout", 1'b0, 1'b1);
  endtask

  task automatic midFrameReset();
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    pix_valid   = 1'b0;
    rst_n       = 1'b0;
    #1;
    checkOutput("reset_cell_valid", cell_valid, 1'b0);
    checkOutput("reset_instr_ready", instr_ready, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_frame_done", frame_done, 1'b0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One frame: model captures each accepted pixel and predicts the cell it completes.
  task automatic applyStimulus(input logic [3:0] op, input logic [23:0] user, input bit formulaPix,
                               input bit togglePix, input int rdyMode, input int stopAfter);
    bit            ok;
    int            x, y, accepted, guard, doneBefore;
    bit            havePend;
    logic [PD-1:0] pend;
    cell_t         e;
    cellsSeen  = 0;
    stallDone  = 0;
    readyMode  = rdyMode;
    doneBefore = doneCount;
    sendInstr(op, user, ok);
    if (!ok) return;
    @(negedge clk);
    checkOutput("busy_in_run", busy, 1'b1);
    checkOutput("instr_ready_in_run", instr_ready, 1'b0);
    x = 0; y = 0; accepted = 0; guard = 0; havePend = 0; pend = '0;
    while (accepted < W * H && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
      if (!havePend) begin
        pend = formulaPix ? {8'(y), 8'(x), 8'(5 * y + x)} : 24'($urandom);
        havePend = 1;
      end
      pix_data     = pend;
      pix_valid    = togglePix ? !pix_valid : 1'b1;
      instr_valid  = 1'($urandom_range(0, 1));
      instr_opcode = 4'($urandom);
      instr_user   = 24'($urandom);
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        img[y][x] = pend;
        havePend  = 0;
        if (x >= 2 && y >= 2) begin
          e = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              e.data[PD*(r*3+c) +: PD] = img[y-2+r][x-2+c];
          e.x    = 10'(x - 1);
          e.y    = 9'(y - 1);
          e.op   = op;
          e.user = user;
          e.last = (x == W - 1) && (y == H - 1);
          expQ.push_back(e);
        end
        accepted++;
        if (x == W - 1) begin
          x = 0;
          y++;
        end else begin
          x++;
        end
        if (stopAfter > 0 && accepted == stopAfter) begin
          midFrameReset();
          return;
        end
      end
    end
    if (accepted < W * H) checkOutput("pixel_timeout", accepted, W * H);
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    instr_valid = 1'b0;
    guard = 0;
    while (doneCount == doneBefore && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("frame_done_count", doneCount - doneBefore, 1);
    repeat (2) @(negedge clk);
    checkOutput("cells_per_frame", cellsSeen, CELLS);
    checkOutput("queue_empty", expQ.size(), 0);
    checkOutput("idle_after_frame", {busy, instr_ready}, 2'b01);
  endtask

  initial begin : stimulus
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr_opcode = '0;
    instr_user   = '0;
    pix_valid    = 1'b0;
    pix_data     = '0;
    #12;
    checkOutput("rst_cell_valid", cell_valid, 1'b0);
    checkOutput("rst_instr_ready", instr_ready, 1'b1);
    checkOutput("rst_pix_ready", pix_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_frame_done", frame_done, 1'b0);
    checkOutput("rst_instr_error", instr_error, 1'b0);
    checkOutput("rst_cell_data", cell_data, '0);
    checkOutput("rst_cell_xy", {cell_x, cell_y}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] frame with formula pixels, consumer always ready");
    applyStimulus(OP_ADD, 24'h123456, 1, 0, 0, 0);
    $display("[TB] same frame with a 4-cycle stall at the third cell");
    applyStimulus(OP_ADD, 24'h123456, 1, 0, 1, 0);

    $display("[TB] illegal opcode 13 in IDLE");
    @(posedge clk);
    #1;
    instr_valid  = 1'b1;
    instr_opcode = 4'd13;
    instr_user   = 24'($urandom);
    @(negedge clk);
    checkOutput("err_instr_ready", instr_ready, 1'b1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_pulse", instr_error, 1'b1);
    checkOutput("err_stays_idle", {busy, instr_ready}, 2'b01);
    @(negedge clk);
    checkOutput("err_pulse_end", instr_error, 1'b0);
    checkOutput("err_still_idle", {busy, instr_ready}, 2'b01);
    applyStimulus(OP_ADDI, 24'h0A0A0A, 0, 0, 2, 0);

    $display("[TB] reset mid-frame, then a full frame");
    applyStimulus(OP_ADD, 24'($urandom), 0, 0, 0, 14);
    applyStimulus(OP_ADD, 24'($urandom), 1, 0, 0, 0);

    $display("[TB] toggling pix_valid with random consumer");
    applyStimulus(4'd11, 24'($urandom), 0, 1, 2, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(4'($urandom_range(0, 11)), 24'($urandom), 0, 1'(i % 2), 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
